self_sprite_datapath: RTL and testbench
=======================================

Name: self_sprite_datapath

Overview:
- Datapath stage directly downstream of the game control FSM.
- Holds the player sprite's position and applies button moves when the FSM pulses load_coord.
- While the FSM holds draw_en in a draw or erase state, it scans the 5x5 sprite pixel by pixel and emits x/y/colour/plot to the VGA adapter.
- Exports the current position so a collision checker can drive the FSM's game_over input.

Parameters:
- SPRITE_W, 5, sprite width in pixels
- SPRITE_H, 5, sprite height in pixels
- X_MAX, 160, screen width
- Y_MAX, 120, screen height
- X_INIT, 78, reset x position (top-left corner)
- Y_INIT, 110, reset y position (top-left corner)
- STEP, 1, pixels moved per load_coord
- DRAW_COLOUR, 3'b110, colour when self_state == 1
- BG_COLOUR, 3'b000, colour when self_state == 2 (erase)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- move_en  input  1  button sampling enable from FSM
- load_coord  input  1  one-cycle pulse: apply pending move
- draw_en  input  1  pixel scan enable (FSM self_done_en)
- self_state  input  4  1 = draw, 2 = erase, other = idle
- left, right, up, down  input  1 each  synchronised, active-high buttons
- x_out  output  8  pixel x to VGA adapter
- y_out  output  7  pixel y to VGA adapter
- colour_out  output  3  pixel colour
- plot_out  output  1  write strobe to VGA adapter
- done  output  1  scan complete
- pos_x  output  8  current sprite x
- pos_y  output  7  current sprite y

Behaviour:
- Reset (async, reset_n = 0):
  - pos_x = X_INIT, pos_y = Y_INIT.
  - Pending-move register = 0; scan counters = 0.
  - x_out = 0, y_out = 0, colour_out = 0, plot_out = 0.
  - done = 0.
  - Reset asserted mid-scan aborts the scan immediately.
- Pending move register {pl, pr, pu, pd}:
  - While move_en = 1 and load_coord = 0, each bit ORs in its button every cycle (sticky).
  - Holds its value while move_en = 0.
- On load_coord = 1 with draw_en = 0:
  - Effective move = pending OR current buttons (the buttons are included only if move_en = 1).
  - pos_x/pos_y update per the move rules below; the pending register clears to 0 the same cycle.
- load_coord is ignored while draw_en = 1: the pending register is kept and the position is unchanged.
- Move rules:
  - Horizontal: pl & pr → no move. pl only → pos_x -= STEP if pos_x >= STEP, else clamp to 0. pr only → pos_x += STEP if pos_x + STEP <= X_MAX - SPRITE_W, else clamp to X_MAX - SPRITE_W.
  - Vertical: same rules with pu (decrease) / pd (increase), pos_y, Y_MAX, SPRITE_H.
  - Compute sums at 9 bits to avoid wrap.
- Scan counters:
  - col is 3 bits, row is 3 bits, idx is 5 bits.
  - While draw_en = 0: all hold at 0.
  - While draw_en = 1 and idx < 25: idx += 1; col += 1, wrapping to 0 at SPRITE_W - 1 and incrementing row.
  - When idx == 25 with draw_en = 1: all return to 0 next cycle. This wrap matches the FSM's 26-cycle count (0..25).
- done:
  - Combinational: done = draw_en & (idx == SPRITE_W * SPRITE_H).
  - High exactly one cycle per scan, aligned with the FSM's self_done.
- Pixel output (registered, 1-cycle latency):
  - Let valid = draw_en & (idx < 25) & (self_state == 1 or self_state == 2).
  - Next cycle: plot_out = valid, x_out = pos_x + col, y_out = pos_y + row.
  - colour_out = DRAW_COLOUR if self_state == 1, else BG_COLOUR.
  - When valid = 0: plot_out = 0 next cycle; x_out, y_out and colour_out hold.
- Output order: row-major, 25 plot strobes per scan.
  - First pixel (pos_x, pos_y) appears the cycle after draw_en rises.
  - Last pixel (pos_x + 4, pos_y + 4) appears the same cycle done is high.
- draw_en dropping mid-scan: counters clear next cycle; the next scan restarts at pixel 0.
- self_state changing mid-scan: colour follows the new value from the next pixel.
- Idle self_state with draw_en = 1: counters still run and done still fires; plot_out stays 0.

Test Plan:
- Reset release, draw_en = 1 for 26 cycles with self_state = 1 → 25 plot_out pulses, pixels (78,110)…(82,114) row-major, colour 3'b110, done high only on the 26th cycle.
- left pulsed 1 cycle with move_en = 1, then load_coord → pos_x = 77, pos_y = 110, pending register clears. A second load_coord with no buttons → no change.
- Hold right for 80 load_coord cycles from reset → pos_x saturates at 155 (never 156+). Hold down → pos_y saturates at 115.
- left & right held together, then load_coord → pos_x unchanged. up alone pressed → pos_y decrements by 1.
- Erase scan with self_state = 2 → same 25 coordinates, colour 3'b000. load_coord during the scan → ignored, position unchanged.
- Assert reset_n = 0 asynchronously at pixel 12 → plot_out and done drop immediately, position returns to (78,110). The next scan starts at pixel 0.

Source files
------------

// File: rtl/self_sprite_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : self_sprite_datapath
//  Purpose  : Player sprite position register, button move logic and 5x5
//             pixel scanner feeding the VGA adapter.
//  Revision : 1.0  initial release
// ============================================================================
module self_sprite_datapath #(
    parameter int         SPRITE_W    = 5,
    parameter int         SPRITE_H    = 5,
    parameter int         X_MAX       = 160,
    parameter int         Y_MAX       = 120,
    parameter int         X_INIT      = 78,
    parameter int         Y_INIT      = 110,
    parameter int         STEP        = 1,
    parameter logic [2:0] DRAW_COLOUR = 3'b110,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       move_en,
    input  logic       load_coord,
    input  logic       draw_en,
    input  logic [3:0] self_state,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot_out,
    output logic       done,
    output logic [7:0] pos_x,
    output logic [6:0] pos_y
);

    localparam logic [8:0] c_step     = 9'(STEP);
    localparam logic [8:0] c_x_lim    = 9'(X_MAX - SPRITE_W);
    localparam logic [8:0] c_y_lim    = 9'(Y_MAX - SPRITE_H);
    localparam logic [4:0] c_npix     = 5'(SPRITE_W * SPRITE_H);
    localparam logic [2:0] c_col_last = 3'(SPRITE_W - 1);
    localparam logic [3:0] c_st_draw  = 4'd1;
    localparam logic [3:0] c_st_erase = 4'd2;

    // ------------------------------------------------------------------
    // Pending move register {left, right, up, down}
    // ------------------------------------------------------------------
    logic [3:0] w_btn;
    logic [3:0] r_pend;
    logic [3:0] w_eff;
    logic       w_load;

    assign w_btn  = {left, right, up, down};
    assign w_eff  = r_pend | (move_en ? w_btn : 4'b0000);
    assign w_load = load_coord & ~draw_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= 4'b0000;
        end else if (w_load) begin
            r_pend <= 4'b0000;
        end else if (move_en && !load_coord) begin
            r_pend <= r_pend | w_btn;
        end
    end

    // ------------------------------------------------------------------
    // Next position with clamping; sums held at 9 bits so they cannot wrap
    // ------------------------------------------------------------------
    logic [7:0] r_pos_x;
    logic [6:0] r_pos_y;
    logic [8:0] w_x_ext;
    logic [8:0] w_y_ext;
    logic [8:0] w_x_inc;
    logic [8:0] w_y_inc;
    logic [7:0] w_next_x;
    logic [6:0] w_next_y;

    assign w_x_ext = {1'b0, r_pos_x};
    assign w_y_ext = {2'b00, r_pos_y};
    assign w_x_inc = w_x_ext + c_step;
    assign w_y_inc = w_y_ext + c_step;

    always_comb begin
        w_next_x = r_pos_x;
        case ({w_eff[3], w_eff[2]})
            2'b10:   w_next_x = (w_x_ext >= c_step) ? 8'(w_x_ext - c_step) : 8'd0;
            2'b01:   w_next_x = (w_x_inc <= c_x_lim) ? w_x_inc[7:0] : c_x_lim[7:0];
            default: w_next_x = r_pos_x;
        endcase
    end

    always_comb begin
        w_next_y = r_pos_y;
        case ({w_eff[1], w_eff[0]})
            2'b10:   w_next_y = (w_y_ext >= c_step) ? 7'(w_y_ext - c_step) : 7'd0;
            2'b01:   w_next_y = (w_y_inc <= c_y_lim) ? w_y_inc[6:0] : c_y_lim[6:0];
            default: w_next_y = r_pos_y;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos_x <= 8'(X_INIT);
            r_pos_y <= 7'(Y_INIT);
        end else if (w_load) begin
            r_pos_x <= w_next_x;
            r_pos_y <= w_next_y;
        end
    end

    assign pos_x = r_pos_x;
    assign pos_y = r_pos_y;

    // ------------------------------------------------------------------
    // Scan counters: idx runs 0..npix so the scan lasts npix+1 cycles,
    // matching the control FSM's own count.
    // ------------------------------------------------------------------
    logic [2:0] r_col;
    logic [2:0] r_row;
    logic [4:0] r_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col <= 3'd0;
            r_row <= 3'd0;
            r_idx <= 5'd0;
        end else if (!draw_en || (r_idx >= c_npix)) begin
            r_col <= 3'd0;
            r_row <= 3'd0;
            r_idx <= 5'd0;
        end else begin
            r_idx <= r_idx + 5'd1;
            if (r_col == c_col_last) begin
                r_col <= 3'd0;
                r_row <= r_row + 3'd1;
            end else begin
                r_col <= r_col + 3'd1;
            end
        end
    end

    assign done = draw_en & (r_idx == c_npix);

    // ------------------------------------------------------------------
    // Registered pixel output
    // ------------------------------------------------------------------
    logic       w_state_active;
    logic       w_valid;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;
    logic       r_plot;

    assign w_state_active = (self_state == c_st_draw) || (self_state == c_st_erase);
    assign w_valid        = draw_en & (r_idx < c_npix) & w_state_active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
        end else begin
            r_plot <= w_valid;
            if (w_valid) begin
                r_x      <= r_pos_x + {5'd0, r_col};
                r_y      <= r_pos_y + {4'd0, r_row};
                r_colour <= (self_state == c_st_draw) ? DRAW_COLOUR : BG_COLOUR;
            end
        end
    end

    assign x_out      = r_x;
    assign y_out      = r_y;
    assign colour_out = r_colour;
    assign plot_out   = r_plot;

endmodule
`default_nettype wire

// File: tb/tb_self_sprite_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_self_sprite_datapath
//  Purpose  : Scoreboard bench for the sprite datapath.
//  Revision : 1.0  initial release
// ============================================================================
module tb_self_sprite_datapath;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       move_en, load_coord, draw_en;
    logic [3:0] self_state;
    logic       left, right, up, down;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot_out, done;
    logic [7:0] pos_x;
    logic [6:0] pos_y;

    self_sprite_datapath dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .move_en    (move_en),
        .load_coord (load_coord),
        .draw_en    (draw_en),
        .self_state (self_state),
        .left       (left),
        .right      (right),
        .up         (up),
        .down       (down),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot_out   (plot_out),
        .done       (done),
        .pos_x      (pos_x),
        .pos_y      (pos_y)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int mx, my;
    logic [17:0] sb_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference move model: step 1, x limited to 0..155, y to 0..115
    function automatic void model_move(input logic [3:0] b);
        if (b[3] && !b[2]) mx = (mx >= 1) ? mx - 1 : 0;
        else if (b[2] && !b[3]) mx = (mx + 1 <= 155) ? mx + 1 : 155;
        if (b[1] && !b[0]) my = (my >= 1) ? my - 1 : 0;
        else if (b[0] && !b[1]) my = (my + 1 <= 115) ? my + 1 : 115;
    endfunction

    always @(negedge clk) begin
        if (reset_n && plot_out) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_plot", plot_out, 0);
            end else begin
                logic [17:0] e;
                e = sb_q.pop_front();
                check("pix_x", x_out, e[17:10]);
                check("pix_y", y_out, e[9:3]);
                check("pix_colour", colour_out, e[2:0]);
            end
        end
    end

    task automatic scan(input logic [3:0] st, input bit lc_mid);
        bit active;
        active = (st == 4'd1) || (st == 4'd2);
        if (active) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    sb_q.push_back({8'(mx + c), 7'(my + r), (st == 4'd1) ? 3'b110 : 3'b000});
        end
        @(posedge clk); #1;
        draw_en    = 1'b1;
        self_state = st;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            check("done", done, (c == 25) ? 1 : 0);
            if (c == 0)  check("plot_first_cycle", plot_out, 0);
            if (c == 25) check("plot_last_pixel", plot_out, active ? 1 : 0);
            if (lc_mid && c == 10) load_coord = 1'b1;
            if (lc_mid && c == 11) load_coord = 1'b0;
        end
        @(posedge clk); #1;
        draw_en    = 1'b0;
        self_state = 4'd0;
        @(negedge clk);
        check("plot_after_scan", plot_out, 0);
        check("sb_drained", sb_q.size(), 0);
        check("scan_pos_x", pos_x, mx);
        check("scan_pos_y", pos_y, my);
    endtask

    task automatic pulse_move(input logic [3:0] btn);
        @(posedge clk); #1;
        move_en = 1'b1;
        {left, right, up, down} = btn;
        @(posedge clk); #1;
        move_en = 1'b0;
        {left, right, up, down} = 4'b0000;
        load_coord = 1'b1;
        @(posedge clk); #1;
        load_coord = 1'b0;
        model_move(btn);
        @(negedge clk);
        check("move_pos_x", pos_x, mx);
        check("move_pos_y", pos_y, my);
    endtask

    task automatic hold_load(input logic [3:0] btn, input int n);
        @(posedge clk); #1;
        move_en    = 1'b1;
        load_coord = 1'b1;
        {left, right, up, down} = btn;
        repeat (n) begin
            @(posedge clk);
            model_move(btn);
        end
        #1;
        move_en    = 1'b0;
        load_coord = 1'b0;
        {left, right, up, down} = 4'b0000;
        @(negedge clk);
        check("hold_pos_x", pos_x, mx);
        check("hold_pos_y", pos_y, my);
    endtask

    initial begin
        reset_n    = 1'b0;
        move_en    = 1'b0;
        load_coord = 1'b0;
        draw_en    = 1'b0;
        self_state = 4'd0;
        {left, right, up, down} = 4'b0000;
        mx = 78;
        my = 110;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pos_x", pos_x, 78);
        check("rst_pos_y", pos_y, 110);
        check("rst_x_out", x_out, 0);
        check("rst_y_out", y_out, 0);
        check("rst_colour", colour_out, 0);
        check("rst_plot", plot_out, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        scan(4'd1, 1'b0);
        pulse_move(4'b1000);
        pulse_move(4'b0000);
        hold_load(4'b0100, 80);
        check("sat_x", pos_x, 155);
        hold_load(4'b0001, 80);
        check("sat_y", pos_y, 115);
        pulse_move(4'b1100);
        pulse_move(4'b0010);
        scan(4'd0, 1'b0);

        // Leave a left move pending, then show load_coord is ignored mid-scan
        @(posedge clk); #1;
        move_en = 1'b1;
        left    = 1'b1;
        @(posedge clk); #1;
        move_en = 1'b0;
        left    = 1'b0;
        scan(4'd2, 1'b1);
        @(posedge clk); #1;
        load_coord = 1'b1;
        @(posedge clk); #1;
        load_coord = 1'b0;
        model_move(4'b1000);
        @(negedge clk);
        check("pending_kept_x", pos_x, mx);

        // Asynchronous reset with pixel 12 on the outputs
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                sb_q.push_back({8'(mx + c), 7'(my + r), 3'b110});
        @(posedge clk); #1;
        draw_en    = 1'b1;
        self_state = 4'd1;
        repeat (13) @(posedge clk);
        #1;
        check("plot_pre_rst", plot_out, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_plot", plot_out, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_pos_x", pos_x, 78);
        check("rst_mid_pos_y", pos_y, 110);
        sb_q.delete();
        mx = 78;
        my = 110;
        draw_en    = 1'b0;
        self_state = 4'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        scan(4'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
